// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator producing one-hot gt/eq/lt flags.
// Define SIGNED_COMPARE_EN to treat operands as two's complement instead of unsigned.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic a_gt_b,
    output logic a_eq_b,
    output logic a_lt_b
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             decided_q, decided_d;
    logic             gt_int_q, gt_int_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             mismatch_gt;

`ifdef SIGNED_COMPARE_EN
    // A set sign bit makes an operand smaller, so an MSB mismatch favours the operand with b's bit.
    assign mismatch_gt = (cnt_q == '0) ? b_bit : a_bit;
`else
    assign mismatch_gt = a_bit;
`endif

    // NOTE: every variable driven here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        gt_int_d  = gt_int_q;
        gt_d      = gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SHIFT;
                    cnt_d     = '0;
                    decided_d = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (bit_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!decided_q && (a_bit != b_bit)) begin
                        decided_d = 1'b1;
                        gt_int_d  = mismatch_gt;
                    end
                    // Result registers use this cycle's decision so the last bit can still decide.
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        eq_d    = ~decided_d;
                        gt_d    = decided_d & gt_int_d;
                        lt_d    = decided_d & ~gt_int_d;
                    end
                end
            end

            ST_DONE: begin
                if (start) begin
                    state_d   = ST_SHIFT;
                    cnt_d     = '0;
                    decided_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_int_q  <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            gt_int_q  <= gt_int_d;
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign a_gt_b = gt_q;
    assign a_eq_b = eq_q;
    assign a_lt_b = lt_q;

endmodule
